// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier.
// Retires one multiplier bit per clock and produces Result = A * B after
// WIDTH iteration edges. It shares the Start/Busy/Done handshake with the
// divider, so the ALU decoder can drive either one the same way.
module shift_add_multiplier #(
    parameter int WIDTH = 3
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic                 Start,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic [2*WIDTH-1:0]   Result,
    output logic                 Busy,
    output logic                 Done
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             next_state;

    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [WIDTH:0]     acc;
    logic [CW-1:0]      count;
    logic [WIDTH:0]     sum;
    logic [WIDTH-1:0]   addend;
    logic               last_iter;

    // State register; Reset returns to IDLE and drops any operation in flight.
    always_ff @(posedge Clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the values from before the edge, whatever the statement order.
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: IDLE accepts Start; RUN leaves after the final iteration.
    always_comb begin
        // NOTE: assigning the default first means no path leaves next_state
        // unassigned, so no latch is inferred.
        next_state = state;
        case (state)
            IDLE: if (Start) next_state = RUN;
            RUN:  if (last_iter) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One iteration: add the multiplicand when the current multiplier bit is set.
    // acc[WIDTH] is always zero after the right shift, so adding the full acc
    // equals adding its low WIDTH bits; the carry lands in sum[WIDTH].
    always_comb begin
        addend    = mplier[0] ? mcand : '0;
        sum       = acc + {1'b0, addend};
        last_iter = (count == CW'(1));
    end

    // Datapath: load operands on Start, then shift {sum, mplier} right each edge.
    // Result is written only at the final iteration edge, where Done pulses.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            count  <= '0;
            Result <= '0;
            Done   <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        mcand  <= A;
                        mplier <= B;
                        acc    <= '0;
                        count  <= CW'(WIDTH);
                    end
                end
                RUN: begin
                    acc    <= {1'b0, sum[WIDTH:1]};
                    mplier <= {sum[0], mplier[WIDTH-1:1]};
                    count  <= count - CW'(1);
                    if (last_iter) begin
                        Result <= {sum, mplier[WIDTH-1:1]};
                        Done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Busy follows state directly, so it is already low in the Done cycle.
    assign Busy = (state == RUN);

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed bench for shift_add_multiplier: a WIDTH=3 instance for the handshake
// scenarios and a WIDTH=4 instance swept over every operand pair.
module tb_shift_add_multiplier;

    logic        Clock;
    logic        Reset;

    logic        start3;
    logic [2:0]  a3;
    logic [2:0]  b3;
    logic [5:0]  result3;
    logic        busy3;
    logic        done3;

    logic        start4;
    logic [3:0]  a4;
    logic [3:0]  b4;
    logic [7:0]  result4;
    logic        busy4;
    logic        done4;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier #(.WIDTH(3)) u_mul3 (
        .Clock  (Clock),
        .Reset  (Reset),
        .Start  (start3),
        .A      (a3),
        .B      (b3),
        .Result (result3),
        .Busy   (busy3),
        .Done   (done3)
    );

    shift_add_multiplier #(.WIDTH(4)) u_mul4 (
        .Clock  (Clock),
        .Reset  (Reset),
        .Start  (start4),
        .A      (a4),
        .B      (b4),
        .Result (result4),
        .Busy   (busy4),
        .Done   (done4)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Advance one rising edge; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Start one WIDTH=3 operation and verify latency, product and Done pulse width.
    task automatic run3(input logic [2:0] a, input logic [2:0] b, input logic [5:0] exp, input string tag);
        int lat;
        a3 = a; b3 = b; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            lat++;
            if (done3) break;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_result"}, result3, exp);
        tick();
        check({tag, "_done_low"}, done3, 0);
    endtask

    initial begin
        Reset = 1'b1;
        start3 = 1'b0; a3 = '0; b3 = '0;
        start4 = 1'b0; a4 = '0; b4 = '0;
        #1;

        // Test 1: reset for two cycles, then 3*3.
        tick();
        tick();
        Reset = 1'b0;
        check("reset_result", result3, 0);
        check("reset_busy", busy3, 0);
        check("reset_done", done3, 0);
        a3 = 3'd3; b3 = 3'd3; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        check("t1_busy_c1", busy3, 1);
        check("t1_done_c1", done3, 0);
        tick();
        check("t1_busy_c2", busy3, 1);
        tick();
        check("t1_busy_c3", busy3, 1);
        tick();
        check("t1_done", done3, 1);
        check("t1_busy_done_cycle", busy3, 0);
        check("t1_result", result3, 9);
        tick();
        check("t1_done_low", done3, 0);
        check("t1_result_hold", result3, 9);

        // Test 2: carry path and zero operands.
        run3(3'd7, 3'd7, 6'd49, "t2_7x7");
        run3(3'd0, 3'd5, 6'd0, "t2_0x5");
        run3(3'd5, 3'd0, 6'd0, "t2_5x0");

        // Test 3: Start during RUN and mid-run operand changes are ignored.
        a3 = 3'd2; b3 = 3'd3; start3 = 1'b1;
        tick();
        a3 = 3'd7; b3 = 3'd7;
        tick();
        start3 = 1'b0;
        a3 = 3'd1; b3 = 3'd1;
        check("t3_busy", busy3, 1);
        tick();
        check("t3_done_early", done3, 0);
        tick();
        check("t3_done", done3, 1);
        check("t3_result", result3, 6);
        tick();
        check("t3_no_second_done", done3, 0);
        check("t3_idle", busy3, 0);
        tick();
        check("t3_no_second_done2", done3, 0);

        // Test 4: Start held high gives back-to-back operations.
        a3 = 3'd5; b3 = 3'd6; start3 = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("t4_done1", done3, 1);
        check("t4_result1", result3, 30);
        a3 = 3'd4; b3 = 3'd4;
        tick();
        check("t4_restart_busy", busy3, 1);
        check("t4_restart_done_low", done3, 0);
        check("t4_result_hold", result3, 30);
        tick();
        tick();
        start3 = 1'b0;
        tick();
        check("t4_done2", done3, 1);
        check("t4_result2", result3, 16);
        tick();
        check("t4_idle", busy3, 0);

        // Test 5: Reset at the second RUN edge aborts the operation.
        a3 = 3'd6; b3 = 3'd5; start3 = 1'b1;
        tick();
        start3 = 1'b0;
        tick();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("t5_busy", busy3, 0);
        check("t5_result", result3, 0);
        check("t5_done", done3, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_done", done3, 0);
        end
        check("t5_result_after", result3, 0);
        run3(3'd1, 3'd1, 6'd1, "t5_1x1");

        // Test 6: WIDTH=4 exhaustive sweep against a behavioural product.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                int lat;
                int prod;
                prod = a * b;
                a4 = 4'(a); b4 = 4'(b); start4 = 1'b1;
                tick();
                start4 = 1'b0;
                lat = 0;
                for (int i = 0; i < 12; i++) begin
                    tick();
                    lat++;
                    if (done4) break;
                end
                check($sformatf("w4_latency_%0dx%0d", a, b), lat, 4);
                check($sformatf("w4_result_%0dx%0d", a, b), result4, prod);
                tick();
                check($sformatf("w4_done_low_%0dx%0d", a, b), done4, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
